// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wave_seq_pkg;

  localparam int DIV_W = 27;
  localparam int FNC_W = 6;

  typedef enum logic [1:0] {
    WAVE_TRI = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_OFF = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_ZERO = 2'd1,
    ST_RESTART   = 2'd2,
    ST_SETTLE    = 2'd3
  } seq_state_t;

  // Raise a requested divider to the smallest legal value.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] req,
                                                 input logic [DIV_W-1:0] lo);
    return (req < lo) ? lo : req;
  endfunction

endpackage

// File: rtl/wave_sel_mux.sv
// Selects one generator output by waveform code, with OFF and force-to-zero.
// Latency: fnc is registered, 1 cycle behind the generator inputs; sel_fnc is combinational.
// Backpressure: none, free-running every cycle.
module wave_sel_mux
  import wave_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  wave_t            sel,
  input  logic             force_zero,
  input  logic [FNC_W-1:0] tri_fnc,
  input  logic [FNC_W-1:0] saw_fnc,
  input  logic [FNC_W-1:0] sqr_fnc,
  output logic [FNC_W-1:0] sel_fnc,
  output logic [FNC_W-1:0] fnc
);

  logic [FNC_W-1:0] fnc_d;
  logic [FNC_W-1:0] fnc_q;

  // Pick the active generator; OFF contributes a flat zero.
  always_comb begin
    sel_fnc = '0;
    unique case (sel)
      WAVE_TRI: sel_fnc = tri_fnc;
      WAVE_SAW: sel_fnc = saw_fnc;
      WAVE_SQR: sel_fnc = sqr_fnc;
      WAVE_OFF: sel_fnc = '0;
    endcase
  end

  // Blank the output while the generators restart and settle.
  always_comb begin
    fnc_d = force_zero ? '0 : sel_fnc;
  end

  // Output register feeding the pin bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      fnc_q <= '0;
    end else begin
      fnc_q <= fnc_d;
    end
  end

  assign fnc = fnc_q;

endmodule

// File: rtl/wave_sequencer.sv
// Applies waveform/divider commands at a zero crossing; optional zero-wait timeout via WAVE_SEQ_TIMEOUT_EN.
// Latency: outputs registered; fnc lags generators by 1 cycle; switch = wait-for-zero + 1 restart + SETTLE_CYC.
// Backpressure: cmd_ready high only in RUN; upstream holds cmd_valid until accepted.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 27'd100_000,
  parameter logic [DIV_W-1:0] MIN_DIV     = 27'd128,
  parameter int               SETTLE_CYC  = 2,
  parameter logic [DIV_W-1:0] TIMEOUT_CYC = 27'd67_108_863
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_wave,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [FNC_W-1:0] tri_fnc,
  input  logic [FNC_W-1:0] saw_fnc,
  input  logic [FNC_W-1:0] sqr_fnc,
  output logic [DIV_W-1:0] div,
  output logic             gen_rst,
  output logic [FNC_W-1:0] fnc,
  output logic [1:0]       cur_wave,
  output logic             clamped,
  output logic             timeout
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  seq_state_t       state_q, state_d;
  wave_t            cur_wave_q, cur_wave_d;
  wave_t            pend_wave_q, pend_wave_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             clamped_q, clamped_d;
  logic             gen_rst_q, gen_rst_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

  logic             accept;
  logic             zero_seen;
  logic             tmo_hit;
  logic             force_zero;
  logic [FNC_W-1:0] sel_fnc;
  wave_t            req_wave;
  logic [DIV_W-1:0] req_div;

  assign accept    = cmd_valid && cmd_ready_q;
  assign req_wave  = wave_t'(cmd_wave);
  assign req_div   = clamp_div(cmd_div, MIN_DIV);
  assign zero_seen = (sel_fnc == '0) || (cur_wave_q == WAVE_OFF);

  // Sequencer next-state: latch commands, wait for a zero, restart, settle.
  always_comb begin
    state_d      = state_q;
    cur_wave_d   = cur_wave_q;
    pend_wave_d  = pend_wave_q;
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    clamped_d    = clamped_q;
    gen_rst_d    = 1'b0;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          pend_wave_d = req_wave;
          pend_div_d  = req_div;
          clamped_d   = (cmd_div < MIN_DIV);
          // A command matching the live config needs no restart at all.
          if (!((req_wave == cur_wave_q) && (req_div == div_q))) begin
            state_d = ST_WAIT_ZERO;
          end
        end
      end
      ST_WAIT_ZERO: begin
        if (zero_seen || tmo_hit) begin
          state_d    = ST_RESTART;
          gen_rst_d  = 1'b1;
          div_d      = pend_div_q;
          cur_wave_d = pend_wave_q;
        end
      end
      ST_RESTART: begin
        settle_cnt_d = '0;
        state_d      = (SETTLE_CYC == 0) ? ST_RUN : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
    endcase
    cmd_ready_d = (state_d == ST_RUN);
  end

  assign force_zero = (state_d == ST_RESTART) || (state_d == ST_SETTLE);

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cur_wave_q   <= WAVE_OFF;
      pend_wave_q  <= WAVE_OFF;
      div_q        <= DEFAULT_DIV;
      pend_div_q   <= DEFAULT_DIV;
      clamped_q    <= 1'b0;
      gen_rst_q    <= 1'b0;
      cmd_ready_q  <= 1'b1;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_wave_q   <= cur_wave_d;
      pend_wave_q  <= pend_wave_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      clamped_q    <= clamped_d;
      gen_rst_q    <= gen_rst_d;
      cmd_ready_q  <= cmd_ready_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

`ifdef WAVE_SEQ_TIMEOUT_EN
  logic [DIV_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  // Fires on the wait cycle where the count of waited cycles reaches the limit.
  assign tmo_hit = (state_q == ST_WAIT_ZERO) && ((tmo_cnt_q + DIV_W'(1)) == TIMEOUT_CYC);

  // Wait counter runs only in WAIT_ZERO; flag records a forced switch until the next accept.
  always_comb begin
    tmo_cnt_d = '0;
    timeout_d = timeout_q;
    if (state_q == ST_WAIT_ZERO) begin
      tmo_cnt_d = tmo_cnt_q + DIV_W'(1);
    end
    if (accept) begin
      timeout_d = 1'b0;
    end
    if (tmo_hit && !zero_seen) begin
      timeout_d = 1'b1;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  wave_sel_mux u_mux (
    .clk        (clk),
    .rst        (rst),
    .sel        (cur_wave_q),
    .force_zero (force_zero),
    .tri_fnc    (tri_fnc),
    .saw_fnc    (saw_fnc),
    .sqr_fnc    (sqr_fnc),
    .sel_fnc    (sel_fnc),
    .fnc        (fnc)
  );

  assign div       = div_q;
  assign gen_rst   = gen_rst_q;
  assign cur_wave  = cur_wave_q;
  assign clamped   = clamped_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: reset, start from OFF, zero-crossing switch, clamp, identical command, reset mid-wait.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: commands are held until cmd_ready, as upstream would.
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_wave = 2'd3;
  logic [26:0] cmd_div = 27'd0;
  logic [5:0]  tri_fnc = 6'd0;
  logic [5:0]  saw_fnc = 6'd0;
  logic [5:0]  sqr_fnc = 6'd0;
  logic [26:0] div;
  logic        gen_rst;
  logic [5:0]  fnc;
  logic [1:0]  cur_wave;
  logic        clamped;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_sequencer #(
    .TIMEOUT_CYC (27'd20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wave  (cmd_wave),
    .cmd_div   (cmd_div),
    .tri_fnc   (tri_fnc),
    .saw_fnc   (saw_fnc),
    .sqr_fnc   (sqr_fnc),
    .div       (div),
    .gen_rst   (gen_rst),
    .fnc       (fnc),
    .cur_wave  (cur_wave),
    .clamped   (clamped),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for a single cycle; caller has made sure cmd_ready is high.
  task automatic send(input logic [1:0] w, input logic [26:0] d);
    cmd_wave  = w;
    cmd_div   = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // Reset defaults
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_div", 32'(div), 32'd100000);
    chk("rst_wave", 32'(cur_wave), 32'd3);
    chk("rst_fnc", 32'(fnc), 32'd0);
    chk("rst_rdy", 32'(cmd_ready), 32'd1);
    chk("rst_clamp", 32'(clamped), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_grst", 32'(gen_rst), 32'd0);

    // Start from OFF: TRI at div 1280, accept at N
    tri_fnc = 6'd9;
    saw_fnc = 6'd20;
    sqr_fnc = 6'd63;
    send(2'd0, 27'd1280);                       // now N+1
    chk("off_rdy_n1", 32'(cmd_ready), 32'd0);
    chk("off_grst_n1", 32'(gen_rst), 32'd0);
    chk("off_fnc_n1", 32'(fnc), 32'd0);
    tick();                                     // N+2: RESTART
    chk("off_grst_n2", 32'(gen_rst), 32'd1);
    chk("off_div_n2", 32'(div), 32'd1280);
    chk("off_wave_n2", 32'(cur_wave), 32'd0);
    chk("off_fnc_n2", 32'(fnc), 32'd0);
    tick();                                     // N+3
    chk("off_grst_n3", 32'(gen_rst), 32'd0);
    chk("off_fnc_n3", 32'(fnc), 32'd0);
    chk("off_rdy_n3", 32'(cmd_ready), 32'd0);
    tick();                                     // N+4
    chk("off_fnc_n4", 32'(fnc), 32'd0);
    chk("off_rdy_n4", 32'(cmd_ready), 32'd0);
    tick();                                     // N+5
    chk("off_rdy_n5", 32'(cmd_ready), 32'd1);
    chk("off_fnc_n5", 32'(fnc), 32'd9);
    chk("off_clamp", 32'(clamped), 32'd0);

    // Switch TRI -> SQR on a falling triangle
    tri_fnc = 6'd37;
    send(2'd2, 27'd1280);                       // N+1
    chk("zx_rdy_n1", 32'(cmd_ready), 32'd0);
    chk("zx_fnc_37", 32'(fnc), 32'd37);
    tri_fnc = 6'd20;
    tick();                                     // N+2
    chk("zx_fnc_20", 32'(fnc), 32'd20);
    chk("zx_grst_wait", 32'(gen_rst), 32'd0);
    chk("zx_wave_wait", 32'(cur_wave), 32'd0);
    tri_fnc = 6'd0;                             // zero seen this cycle (Z)
    tick();                                     // Z+1
    chk("zx_grst", 32'(gen_rst), 32'd1);
    chk("zx_wave", 32'(cur_wave), 32'd2);
    chk("zx_fnc_rst", 32'(fnc), 32'd0);
    tri_fnc = 6'd5;
    tick();                                     // Z+2
    chk("zx_grst_off", 32'(gen_rst), 32'd0);
    chk("zx_fnc_s1", 32'(fnc), 32'd0);
    tick();                                     // Z+3
    chk("zx_fnc_s2", 32'(fnc), 32'd0);
    chk("zx_rdy_s2", 32'(cmd_ready), 32'd0);
    tick();                                     // Z+4
    chk("zx_rdy_back", 32'(cmd_ready), 32'd1);
    chk("zx_fnc_sqr", 32'(fnc), 32'd63);
    chk("zx_div", 32'(div), 32'd1280);

    // Clamp: request 5 -> 128; then 500 clears the flag
    sqr_fnc = 6'd0;
    send(2'd2, 27'd5);
    chk("cl_flag_set", 32'(clamped), 32'd1);
    chk("cl_rdy_low", 32'(cmd_ready), 32'd0);
    wait_rdy("cl_wait1");
    chk("cl_div", 32'(div), 32'd128);
    chk("cl_flag_hold", 32'(clamped), 32'd1);
    send(2'd2, 27'd500);
    chk("cl_flag_clr", 32'(clamped), 32'd0);
    wait_rdy("cl_wait2");
    chk("cl_div500", 32'(div), 32'd500);

    // Identical command: no restart, output uninterrupted
    sqr_fnc = 6'd40;
    tick();
    send(2'd2, 27'd500);                        // N+1
    chk("id_rdy_n1", 32'(cmd_ready), 32'd1);
    chk("id_grst_n1", 32'(gen_rst), 32'd0);
    chk("id_fnc_n1", 32'(fnc), 32'd40);
    sqr_fnc = 6'd41;
    tick();                                     // N+2
    chk("id_rdy_n2", 32'(cmd_ready), 32'd1);
    chk("id_grst_n2", 32'(gen_rst), 32'd0);
    chk("id_fnc_n2", 32'(fnc), 32'd41);
    chk("id_div", 32'(div), 32'd500);

    // Reset while stuck in WAIT_ZERO
    send(2'd1, 27'd1000);
    tick();
    tick();
    chk("rw_rdy_wait", 32'(cmd_ready), 32'd0);
    chk("rw_fnc_track", 32'(fnc), 32'd41);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_div", 32'(div), 32'd100000);
    chk("rw_wave", 32'(cur_wave), 32'd3);
    chk("rw_fnc", 32'(fnc), 32'd0);
    chk("rw_rdy", 32'(cmd_ready), 32'd1);
    sqr_fnc = 6'd0;
    saw_fnc = 6'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_grst", 32'(gen_rst), 32'd0);
    end
    chk("rw_lost_wave", 32'(cur_wave), 32'd3);
    chk("rw_lost_div", 32'(div), 32'd100000);
    chk("rw_tmo", 32'(timeout), 32'd0);

`ifdef WAVE_SEQ_TIMEOUT_EN
    // Timeout: SAW stuck at 63, limit 20 -> RESTART on wait cycle 21
    send(2'd1, 27'd1280);
    wait_rdy("to_start");
    saw_fnc = 6'd63;
    tick();
    send(2'd0, 27'd1280);                       // wait cycle 1
    for (int k = 1; k < 21; k++) begin
      chk("to_no_grst", 32'(gen_rst), 32'd0);
      if (k < 20) tick();
    end
    chk("to_tmo_before", 32'(timeout), 32'd0);
    tick();                                     // wait cycle 21
    chk("to_grst", 32'(gen_rst), 32'd1);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_wave", 32'(cur_wave), 32'd0);
    wait_rdy("to_done");
    chk("to_flag_hold", 32'(timeout), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Run-time controller for the function-generator waveform datapath. It accepts waveform/frequency commands over a valid/ready handshake and drives the shared `div` bus and generator restart. It selects which generator's 6-bit output reaches the 64-pin bus. Changes take effect only at a zero crossing of the current output, so the analog output has no step discontinuity.

## Interface
- `DEFAULT_DIV`, 27'd100_000: `div` after reset (1 kHz at 100 MHz).
- `MIN_DIV`, 27'd128: smallest legal `div`; smaller requests are clamped up to it.
- `SETTLE_CYC`, 2: cycles the output is held at 0 after generator restart.
- `TIMEOUT_CYC`, 27'd67_108_863: zero-wait limit (only with `WAVE_SEQ_TIMEOUT_EN`).
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command can be accepted; high only in RUN.
- `cmd_wave`  in  2  0 = TRI, 1 = SAW, 2 = SQR, 3 = OFF.
- `cmd_div`  in  27  requested clock divider.
- `tri_fnc`, `saw_fnc`, `sqr_fnc`  in  6 each  generator outputs.
- `div`  out  27  divider driven to all generators.
- `gen_rst`  out  1  one-cycle restart pulse to the generators.
- `fnc`  out  6  selected waveform to the output bus.
- `cur_wave`  out  2  currently active waveform.
- `clamped`  out  1  sticky flag: last accepted `cmd_div` was below `MIN_DIV`.
- `timeout`  out  1  sticky flag: last switch was forced by timeout.

## Operation
- States: RUN, WAIT_ZERO, RESTART, SETTLE.
- **Accept:** a command is accepted when `cmd_valid && cmd_ready`.
  - Latch `pend_wave` and `pend_div = max(cmd_div, MIN_DIV)`.
  - Set `clamped` iff `cmd_div < MIN_DIV`; clear `timeout`.
- **RUN:**
  - If the latched command equals the current (`cur_wave`, `div`), stay in RUN and change nothing.
  - Otherwise go to WAIT_ZERO.
- **WAIT_ZERO:** `fnc` keeps tracking the selected generator.
  - Leave for RESTART once the selected input is 6'd0, or if `cur_wave` is OFF.
- **RESTART:** exactly one cycle.
  - `gen_rst` = 1; `div` <= `pend_div`; `cur_wave` <= `pend_wave`; `fnc` forced to 0.
- **SETTLE:** `fnc` = 0 for `SETTLE_CYC` cycles, then return to RUN.
- **Output mux:** `fnc` = registered mux of the three generator inputs by `cur_wave`. OFF selects 0.
- `cmd_valid` outside RUN is ignored; the upstream holds the command until `cmd_ready`.
- **Reset** (including mid-sequence):
  - State goes to RUN and any pending command is discarded.
  - `div` = `DEFAULT_DIV`, `cur_wave` = OFF, `fnc` = 0, `gen_rst` = 0.
  - `cmd_ready` = 1 from the first cycle after reset; `clamped` = 0, `timeout` = 0.
- Widths: all `div` compares are unsigned 27-bit. The settle counter is sized by `$clog2(SETTLE_CYC+1)`.

## Timing
- All outputs are registered.
- `fnc` lags the generator inputs by 1 cycle.
- Accept at cycle N: `cmd_ready` is low at N+1; WAIT_ZERO is evaluated from N+1.
- Zero seen at cycle Z: RESTART at Z+1 (`gen_rst` high, new `div`/`cur_wave` visible at Z+1).
- SETTLE occupies Z+2 through Z+1+`SETTLE_CYC`; RUN and `cmd_ready` return at Z+2+`SETTLE_CYC`.
- Switch from OFF: RESTART at N+2, `cmd_ready` back at N+3+`SETTLE_CYC`.
- Identical command: `cmd_ready` never drops.

## Configuration
- `WAVE_SEQ_TIMEOUT_EN` defined:
  - A 27-bit counter runs in WAIT_ZERO.
  - When it reaches `TIMEOUT_CYC` with no zero, go to RESTART and set `timeout`.
- Undefined:
  - WAIT_ZERO waits indefinitely.
  - `timeout` is tied to 0 and no counter is built.

## Structure
- Package `wave_seq_pkg`: wave codes (TRI, SAW, SQR, OFF), the state encoding, and the `DIV_W = 27` and `FNC_W = 6` constants.
- Sub-module `wave_sel_mux`: registered 3:1 mux plus OFF/force-zero, producing `fnc`.
- The FSM, command latch and counters live in the top module.

## Test plan
- **Reset defaults:** assert `rst` for 3 cycles, then release -> `div` = 100000, `cur_wave` = 3, `fnc` = 0, `cmd_ready` = 1, flags 0.
- **Start from OFF:** command TRI, `cmd_div` = 1280 -> `gen_rst` pulses at N+2, `fnc` = 0 through SETTLE, `div` = 1280, `cmd_ready` high at N+5.
- **Switch at zero:** switch TRI -> SQR while `tri_fnc` = 37 and falling -> `fnc` tracks `tri_fnc` until `tri_fnc` = 0, `gen_rst` the next cycle, `cur_wave` = 2.
- **Clamp:** `cmd_div` = 5 -> `div` = 128, `clamped` = 1; a following `cmd_div` = 500 clears `clamped`.
- **Identical command:** resend the current config -> no `gen_rst`, `cmd_ready` stays 1, `fnc` uninterrupted.
- **Reset during WAIT_ZERO and timeout:**
  - Assert `rst` in WAIT_ZERO -> defaults restored, pending command lost.
  - With `WAVE_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC` = 20 and the input stuck at 63 -> RESTART at wait cycle 21, `timeout` = 1.
